// File: rtl/lsu_pkg.sv
// Shared types and lane constants for the load/store unit and its alignment helper.
package lsu_pkg;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LH   = 4'd2,
        LW   = 4'd3,
        LBU  = 4'd4,
        LHU  = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } lsu_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_t;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    function automatic logic is_valid_op(lsu_op_t op);
        return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
    endfunction

    function automatic logic is_store(lsu_op_t op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic logic is_misaligned(lsu_op_t op, logic [1:0] lo);
        case (op)
            LW, SW:       return lo != 2'b00;
            LH, LHU, SH:  return lo[0];
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data and merges partial stores
// into the word read back from RAM (little-endian lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_op_t           op,
    input  logic [1:0]        byte_off,
    input  logic [WORD_W-1:0] mem_word,
    input  logic [WORD_W-1:0] store_data,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged_word
);

    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [WORD_W-1:0] shifted;
    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;
    logic [WORD_W-1:0] byte_mask;
    logic [WORD_W-1:0] half_mask;

    always_comb begin
        byte_sh   = {byte_off, 3'b000};
        half_sh   = {byte_off[1], 4'b0000};
        shifted   = mem_word >> byte_sh;
        byte_lane = shifted[BYTE_W-1:0];
        half_lane = byte_off[1] ? mem_word[WORD_W-1:HALF_W] : mem_word[HALF_W-1:0];
        byte_mask = {{(WORD_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << byte_sh;
        half_mask = {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}} << half_sh;
    end

    always_comb begin
        load_data = '0;
        case (op)
            LB:      load_data = {{(WORD_W-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane};
            LBU:     load_data = {{(WORD_W-BYTE_W){1'b0}}, byte_lane};
            LH:      load_data = {{(WORD_W-HALF_W){half_lane[HALF_W-1]}}, half_lane};
            LHU:     load_data = {{(WORD_W-HALF_W){1'b0}}, half_lane};
            LW:      load_data = mem_word;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        case (op)
            SB: merged_word = (mem_word & ~byte_mask) |
                              ({{(WORD_W-BYTE_W){1'b0}}, store_data[BYTE_W-1:0]} << byte_sh);
            SH: merged_word = (mem_word & ~half_mask) |
                              ({{(WORD_W-HALF_W){1'b0}}, store_data[HALF_W-1:0]} << half_sh);
            default: merged_word = mem_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit in front of a registered-read RAM; sub-word stores
// are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [3:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output lsu_state_t        state_dbg
);

    // Handshake: a request is taken on a rising edge where state is IDLE, req_valid=1
    // and op is a defined non-NONE op; busy holds the PC until RESP, where done pulses
    // for one cycle and req_valid is ignored because it still carries the same instruction.

    lsu_state_t        state;
    lsu_op_t           op_in;
    lsu_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic              mis_q;
    logic              accept;
    logic              mis_in;
    logic [31:0]       load_data;
    logic [31:0]       merged_word;
    logic [31-ADDR_W:0] unused_addr_bits;

    assign op_in            = lsu_op_t'(op);
    assign accept           = (state == IDLE) && req_valid && is_valid_op(op_in);
    assign mis_in           = is_misaligned(op_in, addr[1:0]);
    assign unused_addr_bits = addr[31:ADDR_W];

    lsu_align u_align (
        .op          (op_q),
        .byte_off    (addr_q[1:0]),
        .mem_word    (mem_rdata),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata   <= '0;
            mis_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        addr_q  <= addr[ADDR_W-1:0];
                        wdata_q <= wdata;
                        mis_q   <= mis_in;
                        if (mis_in)
                            state <= RESP;
                        else if (op_in == SW)
                            state <= WR;
                        else
                            state <= RD;
                    end
                end
                RD:  state <= CAP;
                // RAM word read in RD is valid here
                CAP: begin
                    if (is_store(op_q)) begin
                        merge_q <= merged_word;
                        state   <= WR;
                    end else begin
                        rdata <= load_data;
                        state <= RESP;
                    end
                end
                WR:  state <= RESP;
                RESP: begin
                    mis_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state register; mem_we is also gated by rst so a reset
    // arriving in WR cannot commit the write at that edge.
    always_comb begin
        busy      = accept || (state inside {RD, CAP, WR});
        done      = (state == RESP);
        misalign  = (state == RESP) && mis_q;
        mem_re    = (state == RD);
        mem_we    = (state == WR) && !rst;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state inside {RD, CAP, WR})
            mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (state == WR)
            mem_wdata = (op_q == SW) ? wdata_q : merge_q;
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, multi-cycle corner sequences,
// and randomized ops against a byte-level memory/load model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [3:0]        op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              misalign;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    lsu_state_t        state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata;
    logic [31:0] model_mem [16];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .state_dbg (state_dbg)
    );

    // registered-read RAM with a backdoor preload port
    logic [31:0] ram [0:1023];
    logic        bd_we;
    logic [9:0]  bd_idx;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr[11:2]];
        if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
        if (bd_we)  ram[bd_idx] <= bd_data;
    end

    // scoreboard helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bd_write(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // driver: issue one op, observe until done (bounded)
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                          input bit hold,
                          output logic [31:0] r, output logic m, output int lat,
                          output int bcnt, output int rcnt, output int wcnt,
                          output logic [ADDR_W-1:0] aa, output bit ok);
        @(negedge clk);
        req_valid = 1'b1; op = o; addr = a; wdata = d;
        r = '0; m = 1'b0; lat = -1; bcnt = 0; rcnt = 0; wcnt = 0; aa = '0; ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (busy) bcnt++;
            if (mem_re) begin rcnt++; aa = mem_addr; end
            if (mem_we) begin wcnt++; aa = mem_addr; end
            if (done) begin
                r = rdata; m = misalign; lat = c; ok = 1'b1;
                break;
            end
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
        end
        if (!hold) req_valid = 1'b0;
    endtask

    // reference model over a byte view of the word
    function automatic bit ref_mis(input logic [3:0] o, input logic [31:0] a);
        if (o == LW || o == SW) return (a % 4) != 0;
        if (o == LH || o == LHU || o == SH) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] w);
        int k;
        int v;
        logic [7:0] by [4];
        for (int i = 0; i < 4; i++) by[i] = 8'((w >> (8 * i)) & 32'hFF);
        k = int'(a % 4);
        case (o)
            LB:  begin v = int'(by[k]); if (v >= 128) v = v - 256; return 32'(v); end
            LBU: return 32'(int'(by[k]));
            LH:  begin v = int'(by[k]) + 256 * int'(by[k+1]); if (v >= 32768) v = v - 65536; return 32'(v); end
            LHU: return 32'(int'(by[k]) + 256 * int'(by[k+1]));
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [3:0] o, input logic [31:0] a,
                                              input logic [31:0] d, input logic [31:0] w);
        int k;
        logic [7:0] by [4];
        logic [31:0] res;
        for (int i = 0; i < 4; i++) by[i] = 8'((w >> (8 * i)) & 32'hFF);
        k = int'(a % 4);
        if (o == SB) by[k] = d[7:0];
        if (o == SH) begin by[k] = d[7:0]; by[k+1] = d[15:8]; end
        if (o == SW) return d;
        res = '0;
        for (int i = 0; i < 4; i++) res = res | (32'(by[i]) << (8 * i));
        return res;
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
        logic        exp_mis;
        int          exp_lat;
        int          exp_re;
        int          exp_we;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [31:0] r;
        logic m;
        int lat, bcnt, rcnt, wcnt;
        logic [ADDR_W-1:0] aa;
        bit ok;
        logic [11:0] ea;
        int extra_re, extra_we;

        vt[0]  = '{LB,  32'h0000_0103, 32'h0,         32'h80FF_1234, 32'hFFFF_FF80, 32'h80FF_1234, 1'b0, 3, 1, 0};
        vt[1]  = '{LHU, 32'h0000_0102, 32'h0,         32'h8001_7777, 32'h0000_8001, 32'h8001_7777, 1'b0, 3, 1, 0};
        vt[2]  = '{LH,  32'h0000_0102, 32'h0,         32'h8001_7777, 32'hFFFF_8001, 32'h8001_7777, 1'b0, 3, 1, 0};
        vt[3]  = '{SB,  32'h0000_0041, 32'h0000_00AB, 32'h1122_3344, 32'hFFFF_8001, 32'h1122_AB44, 1'b0, 4, 1, 1};
        vt[4]  = '{SW,  32'h0000_0082, 32'h1234_5678, 32'hCAFE_D00D, 32'hFFFF_8001, 32'hCAFE_D00D, 1'b1, 1, 0, 0};
        vt[5]  = '{LW,  32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, 1, 0};
        vt[6]  = '{LBU, 32'h0000_0201, 32'h0,         32'hDEAD_BEEF, 32'h0000_00BE, 32'hDEAD_BEEF, 1'b0, 3, 1, 0};
        vt[7]  = '{SH,  32'h0000_0302, 32'h1234_CAFE, 32'hAAAA_BBBB, 32'h0000_00BE, 32'hCAFE_BBBB, 1'b0, 4, 1, 1};
        vt[8]  = '{LH,  32'h0000_0301, 32'h0,         32'h1234_5678, 32'h0000_00BE, 32'h1234_5678, 1'b1, 1, 0, 0};
        vt[9]  = '{LW,  32'hFFFF_F104, 32'h0,         32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 3, 1, 0};
        vt[10] = '{SW,  32'h0000_0110, 32'h55AA_55AA, 32'h0000_0000, 32'h0BAD_F00D, 32'h55AA_55AA, 1'b0, 2, 0, 1};
        vt[11] = '{LB,  32'h0000_0002, 32'h0,         32'h007F_0000, 32'h0000_007F, 32'h007F_0000, 1'b0, 3, 1, 0};
        vt[12] = '{SH,  32'h0000_0005, 32'h0000_9999, 32'h0101_0101, 32'h0000_007F, 32'h0101_0101, 1'b1, 1, 0, 0};

        rst = 1'b1; req_valid = 1'b0; op = '0; addr = '0; wdata = '0;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_done",      32'(done),      32'h0);
        check("rst_misalign",  32'(misalign),  32'h0);
        check("rst_mem_we",    32'(mem_we),    32'h0);
        check("rst_mem_re",    32'(mem_re),    32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", mem_wdata,      32'h0);
        check("rst_rdata",     rdata,          32'h0);
        check("rst_state",     32'(state_dbg), 32'(IDLE));
        rst = 1'b0;

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            bd_write(vt[i].addr[11:2], vt[i].word);
            exp_q.push_back(vt[i].exp_rdata);
            run_op(vt[i].op, vt[i].addr, vt[i].wdata, 1'b0, r, m, lat, bcnt, rcnt, wcnt, aa, ok);
            check($sformatf("v%0d_done_seen", i), 32'(ok), 32'h1);
            check($sformatf("v%0d_rdata", i), r, exp_q.pop_front());
            check($sformatf("v%0d_misalign", i), 32'(m), 32'(vt[i].exp_mis));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vt[i].exp_lat));
            check($sformatf("v%0d_re_count", i), 32'(rcnt), 32'(vt[i].exp_re));
            check($sformatf("v%0d_we_count", i), 32'(wcnt), 32'(vt[i].exp_we));
            if (vt[i].exp_re + vt[i].exp_we > 0) begin
                ea = vt[i].addr[11:0] & 12'hFFC;
                check($sformatf("v%0d_mem_addr", i), 32'(aa), 32'(ea));
            end
            check($sformatf("v%0d_ram_word", i), ram[vt[i].addr[11:2]], vt[i].exp_word);
        end

        // reset while SH sits in WR: write dropped, everything idle next cycle
        bd_write(10'h018, 32'h7777_7777);
        @(negedge clk);
        req_valid = 1'b1; op = SH; addr = 32'h0000_0062; wdata = 32'h0000_BEEF;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            if (mem_we) begin ok = 1'b1; break; end
        end
        check("rstwr_reached_wr", 32'(ok), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstwr_mem_we",    32'(mem_we),    32'h0);
        check("rstwr_state",     32'(state_dbg), 32'(IDLE));
        check("rstwr_busy",      32'(busy),      32'h0);
        check("rstwr_done",      32'(done),      32'h0);
        check("rstwr_misalign",  32'(misalign),  32'h0);
        check("rstwr_mem_re",    32'(mem_re),    32'h0);
        check("rstwr_mem_addr",  32'(mem_addr),  32'h0);
        check("rstwr_mem_wdata", mem_wdata,      32'h0);
        check("rstwr_rdata",     rdata,          32'h0);
        rst = 1'b0;

        // back-to-back LW then SW with req_valid held through RESP
        bd_write(10'h004, 32'h1357_9BDF);
        bd_write(10'h005, 32'hFFFF_FFFF);
        run_op(LW, 32'h0000_0010, 32'h0, 1'b1, r, m, lat, bcnt, rcnt, wcnt, aa, ok);
        check("b2b_lw_done_seen", 32'(ok), 32'h1);
        check("b2b_lw_rdata", r, 32'h1357_9BDF);
        check("b2b_lw_re", 32'(rcnt), 32'h1);
        check("b2b_lw_we", 32'(wcnt), 32'h0);
        run_op(SW, 32'h0000_0014, 32'h2468_ACE0, 1'b1, r, m, lat, bcnt, rcnt, wcnt, aa, ok);
        req_valid = 1'b0;
        check("b2b_sw_done_seen", 32'(ok), 32'h1);
        check("b2b_sw_latency", 32'(lat), 32'h2);
        check("b2b_sw_re", 32'(rcnt), 32'h0);
        check("b2b_sw_we", 32'(wcnt), 32'h1);
        extra_re = 0; extra_we = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (mem_re) extra_re++;
            if (mem_we) extra_we++;
        end
        check("b2b_extra_re", 32'(extra_re), 32'h0);
        check("b2b_extra_we", 32'(extra_we), 32'h0);
        check("b2b_ram_word", ram[10'h005], 32'h2468_ACE0);
        model_rdata = 32'h1357_9BDF;

        // randomized ops in a 16-word window, upper address bits randomized
        for (int k = 0; k < 16; k++) begin
            model_mem[k] = $urandom();
            bd_write(10'h300 + 10'(k), model_mem[k]);
        end
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rd, w;
            int ridx, rlat, rre, rwe;
            bit rmis;
            ro   = 4'($urandom_range(1, 8));
            ra   = {20'($urandom()), 12'hC00 + 12'($urandom_range(0, 63))};
            rd   = $urandom();
            ridx = int'(ra[5:2]);
            w    = model_mem[ridx];
            rmis = ref_mis(ro, ra);
            if (rmis) begin
                rlat = 1; rre = 0; rwe = 0;
            end else if (ro == SW) begin
                rlat = 2; rre = 0; rwe = 1;
            end else if (ro == SB || ro == SH) begin
                rlat = 4; rre = 1; rwe = 1;
            end else begin
                rlat = 3; rre = 1; rwe = 0;
            end
            if (!rmis && ro inside {LB, LH, LW, LBU, LHU}) model_rdata = ref_load(ro, ra, w);
            if (!rmis && ro inside {SB, SH, SW}) model_mem[ridx] = ref_store(ro, ra, rd, w);
            exp_q.push_back(model_rdata);
            run_op(ro, ra, rd, 1'b0, r, m, lat, bcnt, rcnt, wcnt, aa, ok);
            check($sformatf("r%0d_done_seen", i), 32'(ok), 32'h1);
            check($sformatf("r%0d_rdata", i), r, exp_q.pop_front());
            check($sformatf("r%0d_misalign", i), 32'(m), 32'(rmis));
            check($sformatf("r%0d_latency", i), 32'(lat), 32'(rlat));
            check($sformatf("r%0d_re_count", i), 32'(rcnt), 32'(rre));
            check($sformatf("r%0d_we_count", i), 32'(wcnt), 32'(rwe));
            check($sformatf("r%0d_ram_word", i), ram[10'h300 + 10'(ridx)], model_mem[ridx]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
